// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Moore FSM that walks each MIPS instruction through fetch, decode, execute,
// memory and writeback, driving the control lines of a shared-memory
// multicycle datapath. It also keeps a sticky illegal-opcode flag and a
// retired-instruction counter.
// Optional build macro: MCU_STALL_EN adds the mem_ready port. With it,
// FETCH, MEM_RD and MEM_WR wait for memory to finish.
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [OPCODE_W-1:0] funct,
`ifdef MCU_STALL_EN
  input  logic                mem_ready,
`endif
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                ir_write,
  output logic                alu_src_a,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                ext_zero,
  output logic [1:0]          pc_source,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [3:0]          state,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_I_EXEC   = 4'd10;
  localparam logic [3:0] S_I_WB     = 4'd11;
  localparam logic [3:0] S_JR       = 4'd12;
  localparam logic [3:0] S_RST      = 4'd13;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] FN_JR    = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b101;
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = 3'b110;
  localparam logic [ALUOP_W-1:0] ALU_LUI   = 3'b111;

  logic [3:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, fn_q;
  logic                illegal_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                retire_s;
  logic                illegal_set_s;
  logic                mem_ok_s;

`ifdef MCU_STALL_EN
  assign mem_ok_s = mem_ready;
`else
  assign mem_ok_s = 1'b1;
`endif

  // ALU operation for immediate-format instructions, from the latched opcode
  function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ANDI:  imm_alu_op = ALU_AND;
      OP_ORI:   imm_alu_op = ALU_OR;
      OP_SLTI:  imm_alu_op = ALU_SLT;
      OP_SLTIU: imm_alu_op = ALU_SLTU;
      OP_LUI:   imm_alu_op = ALU_LUI;
      default:  imm_alu_op = ALU_ADD;
    endcase
  endfunction

  // Next-state selection, retire strobe and illegal-opcode detection
  always_comb begin
    state_d       = state_q;
    retire_s      = 1'b0;
    illegal_set_s = 1'b0;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: if (mem_ok_s) state_d = S_DECODE; else state_d = S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_RTYPE:        if (funct == FN_JR) state_d = S_JR; else state_d = S_R_EXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
          OP_SLTI, OP_SLTIU, OP_LUI: state_d = S_I_EXEC;
          default: begin
            state_d       = S_FETCH;
            illegal_set_s = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: if (op_q == OP_LW) state_d = S_MEM_RD; else state_d = S_MEM_WR;
      S_MEM_RD:   if (mem_ok_s) state_d = S_MEM_WB; else state_d = S_MEM_RD;
      S_MEM_WR: begin
        if (mem_ok_s) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEM_WR;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB, S_JR: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      default: state_d = S_RST;
    endcase
  end

  // Moore control decode from state and the latched instruction fields
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    ext_zero      = 1'b0;
    pc_source     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ok_s;
        pc_write  = mem_ok_s;
        alu_src_b = 2'b01;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (op_q == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_alu_op(op_q);
        ext_zero  = (op_q == OP_ANDI) || (op_q == OP_ORI);
      end
      S_I_WB: begin
        reg_write = 1'b1;
        alu_op    = imm_alu_op(op_q);
        ext_zero  = (op_q == OP_ANDI) || (op_q == OP_ORI);
      end
      S_JR: begin
        // JR is only entered when the latched funct selected it
        pc_write  = (fn_q == FN_JR);
        pc_source = 2'b11;
      end
      default: pc_source = 2'b00;
    endcase
  end

  // State, instruction-field latch, sticky illegal flag and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RST;
      op_q      <= '0;
      fn_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (illegal_set_s) illegal_q <= 1'b1;
      if (retire_s) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state         = state_q;
  assign illegal_op    = illegal_q;
  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit (counter built 4 bits wide
// so the wrap can be reached quickly). Stall checks are compiled only when
// MCU_STALL_EN is defined.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic        mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, ext_zero;
  logic [1:0]  pc_source, alu_src_b;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic        illegal_op;
  logic [3:0]  instr_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
`ifdef MCU_STALL_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .ir_write(ir_write), .alu_src_a(alu_src_a),
    .reg_write(reg_write), .reg_dst(reg_dst), .ext_zero(ext_zero),
    .pc_source(pc_source), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  // {pcw,pwc,bne,iord}_{mr,mw,m2r,irw}_{asa,rw,rd,ez}_pcsrc_asb_aluop
  logic [18:0] ctl;
  assign ctl = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, ext_zero,
                pc_source, alu_src_b, alu_op};

  localparam logic [18:0] C_NONE   = 19'b0000_0000_0000_00_00_000;
  localparam logic [18:0] C_FETCH  = 19'b1000_1001_0000_00_01_000;
  localparam logic [18:0] C_FSTALL = 19'b0000_1000_0000_00_01_000;
  localparam logic [18:0] C_DEC    = 19'b0000_0000_0000_00_11_000;
  localparam logic [18:0] C_MADDR  = 19'b0000_0000_1000_00_10_000;
  localparam logic [18:0] C_MRD    = 19'b0001_1000_0000_00_00_000;
  localparam logic [18:0] C_MWB    = 19'b0000_0010_0100_00_00_000;
  localparam logic [18:0] C_MWR    = 19'b0001_0100_0000_00_00_000;
  localparam logic [18:0] C_REX    = 19'b0000_0000_1000_00_00_010;
  localparam logic [18:0] C_RWB    = 19'b0000_0000_0110_00_00_000;
  localparam logic [18:0] C_BEQ    = 19'b0100_0000_1000_01_00_001;
  localparam logic [18:0] C_BNE    = 19'b0110_0000_1000_01_00_001;
  localparam logic [18:0] C_JUMP   = 19'b1000_0000_0000_10_00_000;
  localparam logic [18:0] C_JR     = 19'b1000_0000_0000_11_00_000;
  localparam logic [18:0] C_IEXLUI = 19'b0000_0000_1000_00_10_111;
  localparam logic [18:0] C_IWBLUI = 19'b0000_0000_0100_00_00_111;
  localparam logic [18:0] C_IEXORI = 19'b0000_0000_1001_00_10_100;
  localparam logic [18:0] C_IWBORI = 19'b0000_0000_0101_00_00_100;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  localparam logic [5:0] OP_LUI = 6'b001111, OP_ORI = 6'b001101, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_JR = 6'b001000, FN_0 = 6'b000000;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  st;
    logic [18:0] ctl;
    logic [3:0]  cnt;
    logic        ill;
  } vec_t;

  vec_t tbl[36];

  function automatic vec_t v(input logic [5:0] op, input logic [5:0] fn,
                             input logic [3:0] st, input logic [18:0] c,
                             input logic [3:0] cnt, input logic ill);
    v.op = op; v.fn = fn; v.st = st; v.ctl = c; v.cnt = cnt; v.ill = ill;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    tbl[0]  = v(OP_LW,  FN_0,   4'd0,  C_FETCH,  4'd0, 1'b0);
    tbl[1]  = v(OP_LW,  FN_0,   4'd1,  C_DEC,    4'd0, 1'b0);
    tbl[2]  = v(OP_LW,  FN_0,   4'd2,  C_MADDR,  4'd0, 1'b0);
    tbl[3]  = v(OP_LW,  FN_0,   4'd3,  C_MRD,    4'd0, 1'b0);
    tbl[4]  = v(OP_LW,  FN_0,   4'd4,  C_MWB,    4'd0, 1'b0);
    tbl[5]  = v(OP_SW,  FN_0,   4'd0,  C_FETCH,  4'd1, 1'b0);
    tbl[6]  = v(OP_SW,  FN_0,   4'd1,  C_DEC,    4'd1, 1'b0);
    tbl[7]  = v(OP_SW,  FN_0,   4'd2,  C_MADDR,  4'd1, 1'b0);
    tbl[8]  = v(OP_SW,  FN_0,   4'd5,  C_MWR,    4'd1, 1'b0);
    tbl[9]  = v(OP_R,   FN_ADD, 4'd0,  C_FETCH,  4'd2, 1'b0);
    tbl[10] = v(OP_R,   FN_ADD, 4'd1,  C_DEC,    4'd2, 1'b0);
    tbl[11] = v(OP_R,   FN_ADD, 4'd6,  C_REX,    4'd2, 1'b0);
    tbl[12] = v(OP_R,   FN_ADD, 4'd7,  C_RWB,    4'd2, 1'b0);
    tbl[13] = v(OP_BNE, FN_0,   4'd0,  C_FETCH,  4'd3, 1'b0);
    tbl[14] = v(OP_BNE, FN_0,   4'd1,  C_DEC,    4'd3, 1'b0);
    tbl[15] = v(OP_BNE, FN_0,   4'd8,  C_BNE,    4'd3, 1'b0);
    tbl[16] = v(OP_BEQ, FN_0,   4'd0,  C_FETCH,  4'd4, 1'b0);
    tbl[17] = v(OP_BEQ, FN_0,   4'd1,  C_DEC,    4'd4, 1'b0);
    tbl[18] = v(OP_BEQ, FN_0,   4'd8,  C_BEQ,    4'd4, 1'b0);
    tbl[19] = v(OP_R,   FN_JR,  4'd0,  C_FETCH,  4'd5, 1'b0);
    tbl[20] = v(OP_R,   FN_JR,  4'd1,  C_DEC,    4'd5, 1'b0);
    tbl[21] = v(OP_R,   FN_JR,  4'd12, C_JR,     4'd5, 1'b0);
    tbl[22] = v(OP_LUI, FN_0,   4'd0,  C_FETCH,  4'd6, 1'b0);
    tbl[23] = v(OP_LUI, FN_0,   4'd1,  C_DEC,    4'd6, 1'b0);
    tbl[24] = v(OP_LUI, FN_0,   4'd10, C_IEXLUI, 4'd6, 1'b0);
    tbl[25] = v(OP_LUI, FN_0,   4'd11, C_IWBLUI, 4'd6, 1'b0);
    tbl[26] = v(OP_ORI, FN_0,   4'd0,  C_FETCH,  4'd7, 1'b0);
    tbl[27] = v(OP_ORI, FN_0,   4'd1,  C_DEC,    4'd7, 1'b0);
    tbl[28] = v(OP_ORI, FN_0,   4'd10, C_IEXORI, 4'd7, 1'b0);
    tbl[29] = v(OP_ORI, FN_0,   4'd11, C_IWBORI, 4'd7, 1'b0);
    tbl[30] = v(OP_BAD, FN_0,   4'd0,  C_FETCH,  4'd8, 1'b0);
    tbl[31] = v(OP_BAD, FN_0,   4'd1,  C_DEC,    4'd8, 1'b0);
    tbl[32] = v(OP_J,   FN_0,   4'd0,  C_FETCH,  4'd8, 1'b1);
    tbl[33] = v(OP_J,   FN_0,   4'd1,  C_DEC,    4'd8, 1'b1);
    tbl[34] = v(OP_J,   FN_0,   4'd9,  C_JUMP,   4'd8, 1'b1);
    tbl[35] = v(OP_J,   FN_0,   4'd0,  C_FETCH,  4'd9, 1'b1);

    rst = 1'b1; opcode = 6'd0; funct = 6'd0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 0, 32'(state), 32'd13);
    chk("rst_ctl",   0, 32'(ctl), 32'(C_NONE));
    chk("rst_cnt",   0, 32'(instr_retired), 32'd0);
    chk("rst_ill",   0, 32'(illegal_op), 32'd0);
    rst = 1'b0;
    chk("rel_state", 0, 32'(state), 32'd13);
    @(negedge clk);

    // One row per cycle: drive the instruction fields, check, advance
    for (int i = 0; i < 36; i++) begin
      opcode = tbl[i].op;
      funct  = tbl[i].fn;
      chk("state", i, 32'(state), 32'(tbl[i].st));
      chk("ctl",   i, 32'(ctl), 32'(tbl[i].ctl));
      chk("cnt",   i, 32'(instr_retired), 32'(tbl[i].cnt));
      chk("ill",   i, 32'(illegal_op), 32'(tbl[i].ill));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of an LW read cycle
    opcode = OP_LW; funct = FN_0;
    repeat (2) @(negedge clk);
    chk("lw_mrd_state", 0, 32'(state), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_state", 0, 32'(state), 32'd13);
    chk("async_ctl",   0, 32'(ctl), 32'(C_NONE));
    chk("async_cnt",   0, 32'(instr_retired), 32'd0);
    chk("async_ill",   0, 32'(illegal_op), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Counter wrap: 15 jumps reach 15, the 16th wraps to 0
    opcode = OP_J;
    repeat (15) repeat (3) @(negedge clk);
    chk("wrap15_cnt",   0, 32'(instr_retired), 32'd15);
    chk("wrap15_state", 0, 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    chk("wrap0_cnt",    0, 32'(instr_retired), 32'd0);
    chk("wrap0_state",  0, 32'(state), 32'd0);

`ifdef MCU_STALL_EN
    // FETCH stall: no pc/ir write until memory is ready
    opcode = OP_LW; mem_ready = 1'b0;
    chk("fstall_ctl", 0, 32'(ctl), 32'(C_FSTALL));
    @(negedge clk);
    chk("fstall_state", 0, 32'(state), 32'd0);
    mem_ready = 1'b1;
    chk("fready_ctl", 0, 32'(ctl), 32'(C_FETCH));
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rstall_state", k, 32'(state), 32'd3);
      chk("rstall_ctl",   k, 32'(ctl), 32'(C_MRD));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("stall_rst_state", 0, 32'(state), 32'd13);
    chk("stall_rst_ctl",   0, 32'(ctl), 32'(C_NONE));
    mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps, driving datapath control for a shared-memory multicycle datapath.
- Adds an opcode/funct latch, a BNE/JR/LUI-capable ALU-op map, a sticky illegal-opcode flag and a retired-instruction counter.
- Sits between the instruction register and the multicycle datapath.

Parameters:
- OPCODE_W, 6, opcode and funct field width.
- ALUOP_W, 3, ALU operation code width.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  OPCODE_W  IR[31:26]; valid from DECODE onward.
- funct  input  OPCODE_W  IR[5:0].
- mem_ready  input  1  memory done (present only with MCU_STALL_EN).
- pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, ext_zero  output  1 each  datapath controls.
- pc_source  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs register.
- alu_src_b  output  2  00 B, 01 const 4, 10 imm, 11 imm<<2.
- alu_op  output  ALUOP_W  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt, 110 sltu, 111 lui.
- state  output  4  current state, for debug.
- illegal_op  output  1  sticky flag.
- instr_retired  output  CNT_W  retired-instruction count.

Behaviour:
- Reset:
  - state = RST (13); illegal_op = 0; instr_retired = 0; op_q/fn_q = 0.
  - All control outputs are 0 in RST.
  - First rising edge after rst falls: RST -> FETCH.
  - rst asserted in any state returns to RST immediately; no partial writes occur after assertion.
- Outputs are a pure function of state, op_q and fn_q. Unlisted signals are 0.
- FETCH (0): mem_read, ir_write, alu_src_b=01, alu_op=add, pc_write, pc_source=00. Next state: DECODE.
- DECODE (1): alu_src_b=11, alu_op=add. Latches opcode into op_q and funct into fn_q. Next state by opcode:
  - 100011 (LW) or 101011 (SW) -> MEM_ADDR.
  - 000000 with funct 001000 -> JR.
  - 000000 otherwise -> R_EXEC.
  - 000100 or 000101 -> BRANCH.
  - 000010 -> JUMP.
  - 001000, 001001, 001100, 001101, 001010, 001011, 001111 -> I_EXEC.
  - Anything else: illegal_op <= 1, return to FETCH, no retire.
- MEM_ADDR (2): alu_src_a, alu_src_b=10, alu_op=add. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD (3): mem_read, i_or_d. Next: MEM_WB.
- MEM_WB (4): mem_to_reg, reg_write, reg_dst=0. Next: FETCH.
- MEM_WR (5): mem_write, i_or_d. Next: FETCH.
- R_EXEC (6): alu_src_a, alu_src_b=00, alu_op=010. Next: R_WB.
- R_WB (7): reg_dst, reg_write. Next: FETCH.
- BRANCH (8): alu_src_a, alu_op=sub, pc_write_cond, pc_source=01; branch_ne = (op_q==000101). Next: FETCH.
- JUMP (9): pc_write, pc_source=10. Next: FETCH.
- I_EXEC (10): alu_src_a, alu_src_b=10.
  - alu_op: ADDI/ADDIU add, ANDI and, ORI or, SLTI slt, SLTIU sltu, LUI lui.
  - ext_zero=1 for ANDI/ORI.
  - Next: I_WB.
- I_WB (11): reg_write, reg_dst=0; ext_zero and alu_op held as in I_EXEC. Next: FETCH.
- JR (12): pc_write, pc_source=11. Next: FETCH.
- Unused encodings 14-15 -> RST on the next edge.
- Latency in cycles, FETCH inclusive: LW 5; SW, R-type, I-type 4; BEQ, BNE, J, JR 3.
- instr_retired increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, I_WB or JR. It wraps from 2^CNT_W-1 to 0.
- illegal_op is cleared only by reset.

Optional Feature:
- MCU_STALL_EN defined:
  - mem_ready port exists.
  - FETCH, MEM_RD and MEM_WR hold while mem_ready=0, keeping mem_read/mem_write/i_or_d asserted.
  - In FETCH, pc_write and ir_write are asserted only when mem_ready=1.
  - The state advances on the edge where mem_ready=1.
- MCU_STALL_EN undefined: no mem_ready port; each of these states lasts exactly 1 cycle.

Test Plan:
- Reset and first fetch: rst=1 then released -> state=13 with all controls 0; next edge state=0 with mem_read=ir_write=pc_write=1, alu_src_b=01.
- LW: opcode=100011 -> states 0,1,2,3,4,0; reg_write=mem_to_reg=1 only in state 4; instr_retired 0->1.
- BNE then BEQ: opcode=000101 -> state 8 with pc_write_cond=1, branch_ne=1, alu_op=001; opcode=000100 -> branch_ne=0; 3 cycles each.
- R-type/JR/LUI: funct=100000 -> alu_op=010 then reg_dst=reg_write=1; funct=001000 -> state 12, pc_source=11; opcode=001111 -> alu_op=111, ext_zero=0.
- Illegal opcode and counter: opcode=111111 -> illegal_op=1 and return to FETCH, instr_retired unchanged; CNT_W=4 with 16 J instructions -> counter wraps to 0.
- Stall (MCU_STALL_EN): mem_ready=0 for 3 cycles in MEM_RD -> state holds at 3 with mem_read=1; rst mid-stall -> state 13 with all controls 0.
